// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: Mealy hold vector, registered redirect.
// Optional STALL_COUNT_EN adds a saturating count of cycles with any stage held.
module pipeline_ctrl #(
  parameter int unsigned EX_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_multi_start,
  input  logic [EX_CNT_W-1:0] ex_multi_cycles,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                busy
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] EX_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [EX_CNT_W-1:0] remain;
  logic [EX_CNT_W-1:0] remain_nxt;
  logic                ex_req;

  // A zero-length multi-cycle request is no request at all.
  assign ex_req = ex_multi_start && (ex_multi_cycles != '0);

  always_comb begin
    stall      = '0;
    state_nxt  = state;
    remain_nxt = remain;
    case (state)
      RUN: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (ex_req) begin
          stall = STALL_EX;
          if (ex_multi_cycles != EX_CNT_W'(1)) begin
            state_nxt  = EX_WAIT;
            remain_nxt = ex_multi_cycles - EX_CNT_W'(1);
          end
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
      end
      EX_WAIT: begin
        if (flush_req) begin
          state_nxt  = FLUSH;
          remain_nxt = '0;
        end else begin
          stall = STALL_EX;
          // remain counts the EX_WAIT cycles still owed, including this one.
          if (remain <= EX_CNT_W'(1)) begin
            state_nxt  = RUN;
            remain_nxt = '0;
          end else begin
            remain_nxt = remain - EX_CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        state_nxt = flush_req ? FLUSH : RUN;
      end
      default: begin
        state_nxt  = RUN;
        remain_nxt = '0;
      end
    endcase
    if (rst) begin
      stall = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      remain <= '0;
      flush  <= 1'b0;
      new_pc <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      flush  <= flush_req;
      if (flush_req) begin
        new_pc <= flush_pc;
      end
    end
  end

  assign busy = !rst && (state != RUN);

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((stall != '0) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs driven 1ns after each rising edge,
// combinational and registered outputs checked 1ns later in the same cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        ex_multi_start = 1'b0;
  logic [5:0]  ex_multi_cycles = '0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int unsigned checks = 0;
  int unsigned passes = 0;

  pipeline_ctrl #(.EX_CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_id(stallreq_id),
    .ex_multi_start(ex_multi_start),
    .ex_multi_cycles(ex_multi_cycles),
    .flush_req(flush_req),
    .flush_pc(flush_pc),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .busy(busy)
`ifdef STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic id, input logic exs, input logic [5:0] n,
                       input logic fr, input logic [31:0] fpc);
    rst = r; stallreq_id = id; ex_multi_start = exs; ex_multi_cycles = n;
    flush_req = fr; flush_pc = fpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every request asserted
    drive(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
    chk("rst_stall0", 32'(stall), 32'h0);
    chk("rst_busy0", 32'(busy), 32'h0);
    tick();
    drive(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
    chk("rst_stall1", 32'(stall), 32'h0);
    chk("rst_flush1", 32'(flush), 32'h0);
    chk("rst_newpc1", new_pc, 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("rel_stall", 32'(stall), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
    chk("rel_flush", 32'(flush), 32'h0);
    chk("rel_newpc", new_pc, 32'h0);
    tick();

    // ID stall for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 6'd0, 0, 32'h0);
      chk("id_stall", 32'(stall), 32'h07);
      chk("id_busy", 32'(busy), 32'h0);
      tick();
    end
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("id_end", 32'(stall), 32'h0);
    tick();

    // EX N=4 with ID stall held throughout
    drive(0, 1, 1, 6'd4, 0, 32'h0);
    chk("ex4_c1", 32'(stall), 32'h0F);
    chk("ex4_c1_busy", 32'(busy), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 6'd0, 0, 32'h0);
      chk("ex4_wait", 32'(stall), 32'h0F);
      chk("ex4_busy", 32'(busy), 32'h1);
      tick();
    end
    drive(0, 1, 0, 6'd0, 0, 32'h0);
    chk("ex4_after", 32'(stall), 32'h07);
    chk("ex4_after_busy", 32'(busy), 32'h0);
    tick();

    // EX N=1: single cycle, no EX_WAIT
    drive(0, 0, 1, 6'd1, 0, 32'h0);
    chk("ex1_c1", 32'(stall), 32'h0F);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("ex1_after", 32'(stall), 32'h0);
    chk("ex1_busy", 32'(busy), 32'h0);
    tick();

    // EX N=0: no request
    drive(0, 0, 1, 6'd0, 0, 32'h0);
    chk("ex0_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("ex0_busy", 32'(busy), 32'h0);
    tick();

    // EX N=2: new ex_multi_start inside EX_WAIT is ignored
    drive(0, 0, 1, 6'd2, 0, 32'h0);
    chk("ex2_c1", 32'(stall), 32'h0F);
    tick();
    drive(0, 0, 1, 6'd5, 0, 32'h0);
    chk("ex2_c2", 32'(stall), 32'h0F);
    chk("ex2_c2_busy", 32'(busy), 32'h1);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("ex2_after", 32'(stall), 32'h0);
    chk("ex2_after_busy", 32'(busy), 32'h0);
    tick();

    // Flush aborts EX N=10 on its third cycle
    drive(0, 0, 1, 6'd10, 0, 32'h0);
    chk("abort_c1", 32'(stall), 32'h0F);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("abort_c2", 32'(stall), 32'h0F);
    tick();
    drive(0, 0, 0, 6'd0, 1, 32'h0000_0100);
    chk("abort_c3_stall", 32'(stall), 32'h0);
    chk("abort_c3_flush", 32'(flush), 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("abort_flush", 32'(flush), 32'h1);
    chk("abort_newpc", new_pc, 32'h0000_0100);
    chk("abort_fl_stall", 32'(stall), 32'h0);
    chk("abort_fl_busy", 32'(busy), 32'h1);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("abort_run_flush", 32'(flush), 32'h0);
    chk("abort_run_stall", 32'(stall), 32'h0);
    chk("abort_run_busy", 32'(busy), 32'h0);
    tick();

    // Back-to-back flush, ex_multi_start during FLUSH ignored
    drive(0, 0, 0, 6'd0, 1, 32'h20);
    chk("b2b_c1_flush", 32'(flush), 32'h0);
    tick();
    drive(0, 1, 1, 6'd3, 1, 32'h40);
    chk("b2b_c2_flush", 32'(flush), 32'h1);
    chk("b2b_c2_newpc", new_pc, 32'h20);
    chk("b2b_c2_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 1, 1, 6'd3, 0, 32'h0);
    chk("b2b_c3_flush", 32'(flush), 32'h1);
    chk("b2b_c3_newpc", new_pc, 32'h40);
    chk("b2b_c3_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("b2b_end_flush", 32'(flush), 32'h0);
    chk("b2b_end_stall", 32'(stall), 32'h0);
    chk("b2b_end_busy", 32'(busy), 32'h0);
    tick();

    // Reset mid-EX_WAIT
    drive(0, 0, 1, 6'd10, 0, 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("rex_busy", 32'(busy), 32'h1);
    drive(1, 0, 0, 6'd0, 0, 32'h0);
    chk("rex_rst_stall", 32'(stall), 32'h0);
    chk("rex_rst_busy", 32'(busy), 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("rex_after_stall", 32'(stall), 32'h0);
    chk("rex_after_busy", 32'(busy), 32'h0);
    tick();

    // Reset mid-FLUSH
    drive(0, 0, 0, 6'd0, 1, 32'h80);
    tick();
    drive(1, 0, 0, 6'd0, 0, 32'h0);
    chk("rfl_rst_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("rfl_flush", 32'(flush), 32'h0);
    chk("rfl_newpc", new_pc, 32'h0);
    chk("rfl_busy", 32'(busy), 32'h0);
    tick();

`ifdef STALL_COUNT_EN
    drive(1, 0, 0, 6'd0, 0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 6'd0, 0, 32'h0);
      tick();
    end
    drive(0, 0, 1, 6'd4, 0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 6'd0, 0, 32'h0);
      tick();
    end
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("cnt_seven", stall_cycles, 32'd7);
    tick();
    drive(1, 0, 0, 6'd0, 0, 32'h0);
    tick();
    chk("cnt_rst", stall_cycles, 32'd0);
    drive(0, 0, 0, 6'd0, 0, 32'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
